ysyx_22040632_mdu_ctrl: RTL and testbench
=========================================

YSYX_22040632_MDU_CTRL -- requirements
Module: ysyx_22040632_mdu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand and result width.
REQ-002 SHALL have parameter TIMEOUT, default 96: maximum WAIT cycles before an abort.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rrst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: EX stage presents a mul/div operation.
REQ-006 SHALL have port req_kind, input, 2: 01 = mul, 10 = div; 00 and 11 are ignored.
REQ-007 SHALL have port req_signed, input, 2: signedness, bit1 = src1, bit0 = src2.
REQ-008 SHALL have port req_word, input, 1: 32-bit W-variant operation.
REQ-009 SHALL have port req_sel, input, 1: mul selects high half; div selects remainder.
REQ-010 SHALL have ports req_src1 and req_src2, input, XLEN each: operands.
REQ-011 SHALL have port flush, input, 1: pipeline flush or interrupt kill.
REQ-012 SHALL have port accept, input, 1: EX consumes the result this cycle.
REQ-013 SHALL have ports busy and res_valid, output, 1 each, and res_data, output, XLEN.
REQ-014 SHALL have ports op_a and op_b, output, XLEN each: registered operands shared by both units.
REQ-015 SHALL have ports mul_valid, mul_flush, mulw, output, 1 each; mul_signed, output, 2; mul_ready, mul_out_valid, input, 1 each; result_hi and result_lo, input, XLEN each.
REQ-016 SHALL have ports div_valid, div_flush, divw, div_signed, output, 1 each; div_ready, div_out_valid, input, 1 each; quotient and remainder, input, XLEN each.
REQ-017 SHALL have port timeout_err, output, 1: one-cycle abort pulse.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-019 SHALL go IDLE->ISSUE when req_valid && req_kind in {01,10} && !flush, registering kind, signed, word, sel and both operands.
REQ-020 SHALL drive the selected unit's valid high only in ISSUE and hold it until that unit's ready; on valid&&ready go ISSUE->WAIT; the unselected unit's valid SHALL stay 0.
REQ-021 SHALL keep op_a, op_b, mulw/divw and mul_signed/div_signed stable from ISSUE through WAIT; div_signed = registered req_signed[1].
REQ-022 SHALL, in WAIT, on the selected unit's out_valid capture the result into res_data and go to HOLD.
REQ-023 SHALL select the result as: mul -> sel ? result_hi : result_lo; div -> sel ? remainder : quotient.
REQ-024 SHALL, when word=1, set res_data = {32{r[31]}, r[31:0]}.
REQ-025 SHALL hold res_valid=1 throughout HOLD and return to IDLE on accept; a new request SHALL be taken no earlier than the cycle after that return.
REQ-026 SHALL drive busy = (state != IDLE) && !(state == HOLD && accept).
REQ-027 SHALL give a minimum latency of 3 cycles from request to res_valid when ready and out_valid respond immediately.
REQ-028 SHALL, on flush in any non-IDLE state, enter IDLE next cycle and drop res_valid.
REQ-029 SHALL, on flush in ISSUE or WAIT, drive the selected unit's mul_flush/div_flush combinationally that cycle only.
REQ-030 SHALL give flush priority over out_valid, ready, accept and req_valid arriving in the same cycle.
REQ-031 SHALL ignore an out_valid from the unselected unit.
REQ-032 SHALL count WAIT cycles with a counter cleared on entry to WAIT; when the count reaches TIMEOUT, pulse timeout_err and the unit flush for one cycle, load res_data with all ones, and go to HOLD.

Reset
REQ-033 SHALL, while rrst_n=0, drive state=IDLE with busy, res_valid, res_data, op_a, op_b, every valid/flush/mode output, timeout_err and the counter all 0.
REQ-034 SHALL, on reset asserted mid-operation, discard the operation without asserting a unit flush.

Verification
REQ-035 SHALL verify a mul: src1=3, src2=-2, signed=11, sel=0, ready and out_valid immediate with result_lo=-6 -> res_valid on the 3rd cycle, res_data=0xFFFFFFFFFFFFFFFA.
REQ-036 SHALL verify a divw: src1=0x1_0000_0007, src2=2, sel=0, quotient=0x80000003 -> res_data=0xFFFFFFFF80000003.
REQ-037 SHALL verify div_ready held low 5 cycles: div_valid high all 5 cycles, operands stable, busy=1.
REQ-038 SHALL verify flush in the 2nd WAIT cycle: div_flush is a single pulse, res_valid never rises, IDLE next cycle, and a new request is accepted.
REQ-039 SHALL verify no out_valid for 96 cycles -> timeout_err pulse, res_data all ones, res_valid=1 until accept.
REQ-040 SHALL verify accept held low 4 cycles in HOLD: res_valid and res_data stable, busy=1; an asserted req_valid is not taken until after return to IDLE.

Source files
------------

// File: rtl/ysyx_22040632_mdu_ctrl_if.sv
// Bundle between the EX stage, the mul/div controller and the two arithmetic units.
// slave  : controller view (request/accept and unit responses in; result and unit controls out)
// master : environment view (EX stage plus the mul/div units), directions mirrored
interface ysyx_22040632_mdu_ctrl_if #(
   parameter int unsigned XLEN = 64
);
   // EX-stage request side
   logic            req_valid;
   logic [1:0]      req_kind;
   logic [1:0]      req_signed;
   logic            req_word;
   logic            req_sel;
   logic [XLEN-1:0] req_src1;
   logic [XLEN-1:0] req_src2;
   logic            flush;
   logic            accept;
   // result side
   logic            busy;
   logic            res_valid;
   logic [XLEN-1:0] res_data;
   logic            timeout_err;
   // shared operands
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   // multiplier
   logic            mul_valid;
   logic            mul_flush;
   logic            mulw;
   logic [1:0]      mul_signed;
   logic            mul_ready;
   logic            mul_out_valid;
   logic [XLEN-1:0] result_hi;
   logic [XLEN-1:0] result_lo;
   // divider
   logic            div_valid;
   logic            div_flush;
   logic            divw;
   logic            div_signed;
   logic            div_ready;
   logic            div_out_valid;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

   modport slave (
      input  req_valid, req_kind, req_signed, req_word, req_sel, req_src1, req_src2,
      input  flush, accept,
      output busy, res_valid, res_data, timeout_err, op_a, op_b,
      output mul_valid, mul_flush, mulw, mul_signed,
      input  mul_ready, mul_out_valid, result_hi, result_lo,
      output div_valid, div_flush, divw, div_signed,
      input  div_ready, div_out_valid, quotient, remainder
   );

   modport master (
      output req_valid, req_kind, req_signed, req_word, req_sel, req_src1, req_src2,
      output flush, accept,
      input  busy, res_valid, res_data, timeout_err, op_a, op_b,
      input  mul_valid, mul_flush, mulw, mul_signed,
      output mul_ready, mul_out_valid, result_hi, result_lo,
      input  div_valid, div_flush, divw, div_signed,
      output div_ready, div_out_valid, quotient, remainder
   );
endinterface

// File: rtl/ysyx_22040632_mdu_ctrl.sv
// Mul/div sequencing controller: latches one EX-stage request, issues it to the
// multiplier or divider, waits for the result (with a timeout abort) and holds
// it until EX accepts.
// Ports: clk, rrst_n (async active-low), bus (ysyx_22040632_mdu_ctrl_if.slave).
// busy, mul_flush and div_flush are combinational; everything else is decoded
// from or driven by flops.
module ysyx_22040632_mdu_ctrl #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 96
) (
   input logic                      clk,
   input logic                      rrst_n,
   ysyx_22040632_mdu_ctrl_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

   state_e            state_q, state_d;
   logic              is_mul_q, is_mul_d;
   logic [1:0]        signed_q, signed_d;
   logic              word_q, word_d;
   logic              sel_q, sel_d;
   logic [XLEN-1:0]   op_a_q, op_a_d;
   logic [XLEN-1:0]   op_b_q, op_b_d;
   logic [XLEN-1:0]   res_data_q, res_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_err_q, timeout_err_d;

   logic              unit_flush_c;
   logic              sel_ready_c;
   logic              sel_out_valid_c;
   logic [XLEN-1:0]   raw_res_c;
   logic [XLEN-1:0]   res_ext_c;

   // Only the selected unit's handshakes are observed.
   assign sel_ready_c     = is_mul_q ? bus.mul_ready     : bus.div_ready;
   assign sel_out_valid_c = is_mul_q ? bus.mul_out_valid : bus.div_out_valid;

   // Result select, then sign-extend the low word for W-variants.
   assign raw_res_c = is_mul_q ? (sel_q ? bus.result_hi : bus.result_lo)
                               : (sel_q ? bus.remainder : bus.quotient);
   assign res_ext_c = word_q ? {{(XLEN-32){raw_res_c[31]}}, raw_res_c[31:0]} : raw_res_c;

   // Next-state and datapath update; flush outranks every other event.
   always_comb begin
      state_d       = state_q;
      is_mul_d      = is_mul_q;
      signed_d      = signed_q;
      word_d        = word_q;
      sel_d         = sel_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      res_data_d    = res_data_q;
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;
      unit_flush_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && (bus.req_kind == 2'b01 || bus.req_kind == 2'b10) && !bus.flush) begin
               state_d  = ISSUE;
               is_mul_d = (bus.req_kind == 2'b01);
               signed_d = bus.req_signed;
               word_d   = bus.req_word;
               sel_d    = bus.req_sel;
               op_a_d   = bus.req_src1;
               op_b_d   = bus.req_src2;
            end
         end
         ISSUE: begin
            if (bus.flush) begin
               state_d      = IDLE;
               unit_flush_c = 1'b1;
            end else if (sel_ready_c) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (bus.flush) begin
               state_d      = IDLE;
               unit_flush_c = 1'b1;
            end else if (sel_out_valid_c) begin
               state_d    = HOLD;
               res_data_d = res_ext_c;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // TIMEOUT-th silent WAIT cycle: abort the unit and report all ones.
               state_d       = HOLD;
               unit_flush_c  = 1'b1;
               res_data_d    = '1;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (bus.flush || bus.accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q       <= IDLE;
         is_mul_q      <= 1'b0;
         signed_q      <= 2'b00;
         word_q        <= 1'b0;
         sel_q         <= 1'b0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         res_data_q    <= '0;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         is_mul_q      <= is_mul_d;
         signed_q      <= signed_d;
         word_q        <= word_d;
         sel_q         <= sel_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         res_data_q    <= res_data_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.busy        = (state_q != IDLE) && !(state_q == HOLD && bus.accept);
   assign bus.res_valid   = (state_q == HOLD);
   assign bus.res_data    = res_data_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.op_a        = op_a_q;
   assign bus.op_b        = op_b_q;

   assign bus.mul_valid   = (state_q == ISSUE) && is_mul_q;
   assign bus.div_valid   = (state_q == ISSUE) && !is_mul_q;
   assign bus.mul_flush   = unit_flush_c && is_mul_q;
   assign bus.div_flush   = unit_flush_c && !is_mul_q;
   assign bus.mulw        = word_q;
   assign bus.divw        = word_q;
   assign bus.mul_signed  = signed_q;
   assign bus.div_signed  = signed_q[1];
endmodule

// File: tb/tb_ysyx_22040632_mdu_ctrl.sv
// Directed bench for the mul/div controller; the bench plays both EX stage and units.
module tb_ysyx_22040632_mdu_ctrl;
   logic clk;
   logic rrst_n;
   int   n_cmp;
   int   n_err;

   ysyx_22040632_mdu_ctrl_if #(.XLEN(64)) bus ();

   ysyx_22040632_mdu_ctrl #(.XLEN(64), .TIMEOUT(96)) dut (
      .clk    (clk),
      .rrst_n (rrst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [1:0] kind, input logic [1:0] sgn, input logic word,
                      input logic sel, input logic [63:0] a, input logic [63:0] b);
      bus.req_valid  = 1'b1;
      bus.req_kind   = kind;
      bus.req_signed = sgn;
      bus.req_word   = word;
      bus.req_sel    = sel;
      bus.req_src1   = a;
      bus.req_src2   = b;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rrst_n            = 1'b0;
      bus.req_valid     = 1'b0;
      bus.req_kind      = 2'b00;
      bus.req_signed    = 2'b00;
      bus.req_word      = 1'b0;
      bus.req_sel       = 1'b0;
      bus.req_src1      = '0;
      bus.req_src2      = '0;
      bus.flush         = 1'b0;
      bus.accept        = 1'b0;
      bus.mul_ready     = 1'b1;
      bus.mul_out_valid = 1'b1;
      bus.result_hi     = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.result_lo     = 64'hFFFF_FFFF_FFFF_FFFA;
      bus.div_ready     = 1'b1;
      bus.div_out_valid = 1'b0;
      bus.quotient      = '0;
      bus.remainder     = '0;

      // reset values
      #12;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_res_data", bus.res_data, 64'd0);
      chk("rst_op_a", bus.op_a, 64'd0);
      chk("rst_valids", 64'({bus.mul_valid, bus.div_valid, bus.mul_flush, bus.div_flush}), 64'd0);
      chk("rst_modes", 64'({bus.mulw, bus.divw, bus.mul_signed, bus.div_signed, bus.timeout_err}), 64'd0);
      step();
      rrst_n = 1'b1;
      step();

      // signed mul 3 * -2, low half, immediate unit
      req(2'b01, 2'b11, 1'b0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      bus.req_valid = 1'b0;
      chk("mul_issue_valid", 64'({bus.mul_valid, bus.div_valid}), 64'b10);
      chk("mul_op_a", bus.op_a, 64'd3);
      chk("mul_op_b", bus.op_b, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("mul_signed", 64'(bus.mul_signed), 64'b11);
      chk("mul_issue_resv", 64'(bus.res_valid), 64'd0);
      step();
      chk("mul_wait_state", 64'({bus.mul_valid, bus.res_valid, bus.busy}), 64'b001);
      step();
      chk("mul_res_valid3", 64'(bus.res_valid), 64'd1);
      chk("mul_res_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFFA);
      bus.accept = 1'b1;
      #1;
      chk("mul_busy_accept", 64'(bus.busy), 64'd0);
      step();
      bus.accept = 1'b0;
      chk("mul_back_idle", 64'({bus.res_valid, bus.busy}), 64'd0);

      // divw with ready held off 5 cycles; unselected out_valid must be ignored
      bus.div_ready = 1'b0;
      bus.quotient  = 64'h1234_5678_8000_0003;
      bus.remainder = 64'h0000_0000_0000_0001;
      req(2'b10, 2'b10, 1'b1, 1'b0, 64'h1_0000_0007, 64'd2);
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("divr_valids", 64'({bus.div_valid, bus.mul_valid, bus.busy}), 64'b101);
         chk("divr_ops", {bus.op_a[31:0], bus.op_b[31:0]}, {32'h0000_0007, 32'd2});
         chk("divr_modes", 64'({bus.divw, bus.div_signed}), 64'b11);
         if (i < 4) step();
      end
      bus.div_ready = 1'b1;
      step();
      chk("divw_wait_ignore_mul", 64'({bus.div_valid, bus.res_valid}), 64'd0);
      bus.div_out_valid = 1'b1;
      step();
      bus.div_out_valid = 1'b0;
      chk("divw_res_data", bus.res_data, 64'hFFFF_FFFF_8000_0003);

      // accept withheld 4 cycles while a new request waits
      req(2'b01, 2'b00, 1'b0, 1'b0, 64'd5, 64'd7);
      bus.mul_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("hold_stable", {bus.res_data[62:0], bus.res_valid}, {63'h7FFF_FFFF_8000_0003, 1'b1});
         chk("hold_busy", 64'({bus.busy, bus.mul_valid}), 64'b10);
         step();
      end
      bus.accept = 1'b1;
      #1;
      chk("hold_accept_busy", 64'(bus.busy), 64'd0);
      step();
      bus.accept = 1'b0;
      chk("hold_ret_idle", 64'({bus.res_valid, bus.busy, bus.mul_valid}), 64'd0);
      step();
      chk("new_req_taken", 64'({bus.mul_valid, bus.busy}), 64'b11);
      chk("new_req_op_a", bus.op_a, 64'd5);
      bus.req_valid = 1'b0;
      bus.flush = 1'b1;
      #1;
      chk("issue_flush_pulse", 64'({bus.mul_flush, bus.div_flush}), 64'b10);
      step();
      chk("issue_flush_idle", 64'({bus.busy, bus.mul_flush, bus.mul_valid}), 64'd0);
      bus.flush = 1'b0;
      bus.mul_ready = 1'b1;

      // div flushed in its 2nd WAIT cycle, out_valid arriving alongside
      bus.mul_out_valid = 1'b0;
      req(2'b10, 2'b11, 1'b0, 1'b1, 64'd100, 64'd7);
      step();
      bus.req_valid = 1'b0;
      step();
      chk("wait1_no_flush", 64'({bus.div_flush, bus.res_valid, bus.busy}), 64'b001);
      step();
      bus.flush = 1'b1;
      bus.div_out_valid = 1'b1;
      #1;
      chk("wait2_div_flush", 64'({bus.div_flush, bus.mul_flush, bus.res_valid}), 64'b100);
      step();
      bus.flush = 1'b0;
      bus.div_out_valid = 1'b0;
      chk("flush_idle", 64'({bus.div_flush, bus.busy, bus.res_valid}), 64'd0);
      step();
      chk("flush_stays_quiet", 64'({bus.res_valid, bus.busy}), 64'd0);
      // new request after flush: mul high half
      bus.mul_out_valid = 1'b1;
      bus.result_hi = 64'h0000_0000_0000_0001;
      req(2'b01, 2'b11, 1'b0, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      bus.req_valid = 1'b0;
      chk("post_flush_issue", 64'(bus.mul_valid), 64'd1);
      step();
      step();
      chk("mulh_res", {bus.res_data[62:0], bus.res_valid}, {63'd1, 1'b1});
      bus.accept = 1'b1;
      step();
      bus.accept = 1'b0;

      // timeout after 96 silent WAIT cycles
      bus.mul_out_valid = 1'b1;
      req(2'b10, 2'b00, 1'b0, 1'b0, 64'd9, 64'd0);
      step();
      bus.req_valid = 1'b0;
      step();
      for (int i = 0; i < 95; i++) begin
         chk("to_waiting", 64'({bus.div_flush, bus.timeout_err, bus.res_valid}), 64'd0);
         step();
      end
      chk("to_unit_flush", 64'({bus.div_flush, bus.mul_flush}), 64'b10);
      step();
      chk("to_err_pulse", 64'({bus.timeout_err, bus.res_valid, bus.div_flush}), 64'b110);
      chk("to_res_ones", bus.res_data, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      chk("to_err_once", 64'({bus.timeout_err, bus.res_valid}), 64'b01);
      bus.accept = 1'b1;
      step();
      bus.accept = 1'b0;
      chk("to_accepted", 64'(bus.res_valid), 64'd0);

      // reset mid-operation discards without a unit flush
      bus.div_ready = 1'b0;
      req(2'b10, 2'b00, 1'b0, 1'b0, 64'd11, 64'd3);
      step();
      bus.req_valid = 1'b0;
      chk("pre_rst_issue", 64'(bus.div_valid), 64'd1);
      rrst_n = 1'b0;
      #1;
      chk("mid_rst_quiet", 64'({bus.div_flush, bus.div_valid, bus.busy}), 64'd0);
      chk("mid_rst_op_a", bus.op_a, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
